// File: rtl/alu_pkg.sv
// Shared constants for the ALU round-robin scheduler: op selects, flag bit positions, FSM states.
package alu_pkg;

    localparam int unsigned ALU_W = 32;

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_NOT  = 4'b0010;
    localparam logic [3:0] SEL_NOR  = 4'b0011;
    localparam logic [3:0] SEL_XOR  = 4'b0100;
    localparam logic [3:0] SEL_NAND = 4'b0101;
    localparam logic [3:0] SEL_ADD  = 4'b0110;
    localparam logic [3:0] SEL_SUB  = 4'b0111;

    localparam int unsigned FLG_C = 3;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_Z = 1;
    localparam int unsigned FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_rr_sched_if.sv
// Request, ALU and response signal bundle between requesters/ALU (master) and the scheduler (slave).
interface alu_rr_sched_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 32,
    parameter int unsigned IDW  = 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_sel;
    logic [NREQ-1:0]   req_chain;

    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [3:0]        alu_sel;
    logic              alu_cin;
    logic [W-1:0]      alu_y;
    logic              alu_cout;
    logic              alu_neg;
    logic              alu_zero;
    logic              alu_ovf;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_y;
    logic [3:0]        rsp_flags;

    modport slave (
        input  req_valid, req_a, req_b, req_sel, req_chain,
        input  alu_y, alu_cout, alu_neg, alu_zero, alu_ovf,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_sel, alu_cin,
        output rsp_valid, rsp_id, rsp_y, rsp_flags
    );

    modport master (
        output req_valid, req_a, req_b, req_sel, req_chain,
        output alu_y, alu_cout, alu_neg, alu_zero, alu_ovf,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_sel, alu_cin,
        input  rsp_valid, rsp_id, rsp_y, rsp_flags
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward from ptr+1 with wrap.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDW'(cand);
            end
        end
    end
endmodule

// File: rtl/alu_rr_sched.sv
// Time-shares one combinational ALU among NREQ requesters: round-robin grant, one-cycle execute,
// tagged response, and a per-requester carry register for multi-word add/sub chains.
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = ALU_W,
    parameter int unsigned IDW  = 1
) (
    input  logic           clk,
    input  logic           rst,
    alu_rr_sched_if.slave  bus,
    output logic           busy
);
    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [3:0]      sel_q, sel_d;
    logic            cin_q, cin_d;
    logic [W-1:0]    y_q, y_d;
    logic [3:0]      flags_q, flags_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] carry_q, carry_d;
    logic [NREQ-1:0] req_ready_c;

    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_idx;
    logic            arb_any;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Next-state and datapath capture; every register holds unless its state updates it.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        cin_d       = cin_q;
        y_d         = y_q;
        flags_d     = flags_q;
        carry_d     = carry_q;
        req_ready_c = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready_c = arb_grant;
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (arb_idx == IDW'(i)) begin
                            a_d   = bus.req_a[i*W +: W];
                            b_d   = bus.req_b[i*W +: W];
                            sel_d = bus.req_sel[i*4 +: 4];
                            cin_d = bus.req_chain[i] ? carry_q[i] : 1'b0;
                        end
                    end
                    id_d    = arb_idx;
                    ptr_d   = arb_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                y_d            = bus.alu_y;
                flags_d[FLG_C] = bus.alu_cout;
                flags_d[FLG_N] = bus.alu_neg;
                flags_d[FLG_Z] = bus.alu_zero;
                flags_d[FLG_V] = bus.alu_ovf;
                carry_d[id_q]  = bus.alu_cout;
                state_d        = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            cin_q       <= 1'b0;
            y_q         <= '0;
            flags_q     <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            carry_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            cin_q       <= cin_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            carry_q     <= carry_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_sel   = sel_q;
    assign bus.alu_cin   = cin_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_y     = y_q;
    assign bus.rsp_flags = flags_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed plus randomized bench for alu_rr_sched with a behavioural ALU and reference scheduler model.
module tb_alu_rr_sched;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    alu_rr_sched_if #(.NREQ(2), .W(32), .IDW(1)) bus ();

    alu_rr_sched #(.NREQ(2), .W(32), .IDW(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state: per-requester carry and last-served index.
    logic [1:0]  mcarry;
    int          mptr;
    logic [31:0] last_y;
    logic [3:0]  last_f;

    // ALU behaviour: returns {y, C, N, Z, V}; SUB treats Cin and Cout as borrow.
    function automatic logic [35:0] alu_ref(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                                            input logic ci);
        logic [32:0] t;
        logic [31:0] y;
        logic        c;
        logic        v;
        t = '0; y = '0; c = 1'b0; v = 1'b0;
        case (s)
            SEL_AND:  y = a & b;
            SEL_OR:   y = a | b;
            SEL_NOT:  y = ~a;
            SEL_NOR:  y = ~(a | b);
            SEL_XOR:  y = a ^ b;
            SEL_NAND: y = ~(a & b);
            SEL_ADD: begin
                t = {1'b0, a} + {1'b0, b} + {32'd0, ci};
                y = t[31:0]; c = t[32];
                v = (a[31] == b[31]) && (y[31] != a[31]);
            end
            SEL_SUB: begin
                t = {1'b0, a} - {1'b0, b} - {32'd0, ci};
                y = t[31:0]; c = t[32];
                v = (a[31] != b[31]) && (y[31] != a[31]);
            end
            default: y = '0;
        endcase
        return {y, c, y[31], (y == 32'd0), v};
    endfunction

    logic [35:0] alu_r;
    assign alu_r        = alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin);
    assign bus.alu_y    = alu_r[35:4];
    assign bus.alu_cout = alu_r[3];
    assign bus.alu_neg  = alu_r[2];
    assign bus.alu_zero = alu_r[1];
    assign bus.alu_ovf  = alu_r[0];

    function automatic int model_grant(input logic [1:0] m, input int p);
        for (int k = 1; k <= 2; k++) begin
            if (m[(p + k) % 2]) return (p + k) % 2;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int r, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                           input logic ch);
        bus.req_a[r*32 +: 32] = a;
        bus.req_b[r*32 +: 32] = b;
        bus.req_sel[r*4 +: 4] = s;
        bus.req_chain[r]      = ch;
    endtask

    task automatic rand_req(input int r);
        set_req(r, 4'($urandom_range(0, 7)), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
    endtask

    // One arbitration round from IDLE; called and returns just after a rising edge.
    task automatic run_op(input logic [1:0] m, input int hold, input logic [1:0] stall_m, output int g);
        logic [31:0] ea, eb;
        logic [3:0]  es;
        logic        ec;
        logic [35:0] ex;
        logic [1:0]  oh;
        bus.req_valid = m;
        @(negedge clk);
        g  = model_grant(m, mptr);
        oh = (g < 0) ? 2'b00 : 2'(1 << g);
        chk("req_ready_grant", bus.req_ready, oh);
        if (g < 0) begin
            chk("idle_busy", busy, 0);
            @(posedge clk); #1;
        end else begin
            ea = bus.req_a[g*32 +: 32];
            eb = bus.req_b[g*32 +: 32];
            es = bus.req_sel[g*4 +: 4];
            ec = bus.req_chain[g] ? mcarry[g] : 1'b0;
            ex = alu_ref(es, ea, eb, ec);
            @(posedge clk); #1;
            bus.req_valid[g] = 1'b0;
            rand_req(g);
            if (hold > 0) bus.rsp_ready = 1'b0;
            @(negedge clk);
            chk("exec_busy", busy, 1);
            chk("exec_req_ready", bus.req_ready, 0);
            chk("exec_rsp_valid", bus.rsp_valid, 0);
            chk("exec_alu_in", {bus.alu_a, bus.alu_b}, {ea, eb});
            chk("exec_alu_sel_cin", {bus.alu_sel, bus.alu_cin}, {es, ec});
            @(posedge clk); #1;
            bus.req_valid = bus.req_valid | stall_m;
            @(negedge clk);
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_id", bus.rsp_id, g);
            chk("rsp_y", bus.rsp_y, ex[35:4]);
            chk("rsp_flags", bus.rsp_flags, ex[3:0]);
            last_y = bus.rsp_y;
            last_f = bus.rsp_flags;
            for (int k = 1; k <= hold; k++) begin
                @(posedge clk); #1;
                if (k == hold) bus.rsp_ready = 1'b1;
                @(negedge clk);
                chk("stall_rsp_valid", bus.rsp_valid, 1);
                chk("stall_rsp", {bus.rsp_y, bus.rsp_flags}, {ex[35:4], ex[3:0]});
                chk("stall_req_ready", bus.req_ready, 0);
                chk("stall_busy", busy, 1);
            end
            @(posedge clk); #1;
            mcarry[g] = ex[3];
            mptr      = g;
        end
    endtask

    initial begin
        int g;
        int prev_g;
        int rem0;
        int rem1;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_sel = '0; bus.req_chain = '0;
        bus.rsp_ready = 1'b1;
        mcarry = '0; mptr = 1; last_y = '0; last_f = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin}, 0);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_flags}, 0);
        chk("rst_busy_ready", {busy, bus.req_ready}, 0);
        rst = 1'b0;

        // Basic AND from req0
        set_req(0, SEL_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        run_op(2'b01, 0, 2'b00, g);
        chk("t1_y", last_y, 32'hF000_F000);
        chk("t1_id", g, 0);

        // Both requesters contending for three ops each
        rand_req(0); rand_req(1);
        rem0 = 3; rem1 = 3; prev_g = -1;
        for (int i = 0; i < 6; i++) begin
            run_op({rem1 > 0, rem0 > 0}, 0, 2'b00, g);
            if (i > 0) chk("t2_alternate", (g != prev_g), 1);
            if (g == 0) rem0--; else rem1--;
            prev_g = g;
        end
        chk("t2_done", {rem0[1:0], rem1[1:0]}, 0);

        // Carry chain on req1
        set_req(1, SEL_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(2'b10, 0, 2'b00, g);
        chk("t3a", {last_y, last_f}, {32'h0, 4'b1010});
        set_req(1, SEL_ADD, 32'h0, 32'h0, 1'b1);
        run_op(2'b10, 0, 2'b00, g);
        chk("t3b", {last_y, last_f}, {32'h1, 4'b0000});

        // Response backpressure with req0 pending
        rand_req(0);
        run_op(2'b01, 5, 2'b01, g);
        run_op(2'b01, 0, 2'b00, g);
        chk("t4_served", g, 0);

        // Reset during EXEC discards the op and clears carries
        set_req(0, SEL_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0);
        run_op(2'b01, 0, 2'b00, g);
        set_req(1, SEL_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0);
        run_op(2'b10, 0, 2'b00, g);
        set_req(1, SEL_ADD, 32'h5, 32'h5, 1'b1);
        bus.req_valid = 2'b10;
        @(negedge clk);
        chk("t5_grant", bus.req_ready, 2'b10);
        @(posedge clk); #1;
        rst = 1'b1; bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0; mcarry = '0; mptr = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_rsp", {bus.rsp_valid, busy}, 0);
            @(posedge clk); #1;
        end
        set_req(0, SEL_ADD, 32'h0, 32'h0, 1'b1);
        set_req(1, SEL_ADD, 32'h0, 32'h0, 1'b1);
        run_op(2'b11, 0, 2'b00, g);
        chk("t5_first", g, 0);
        chk("t5_y0", last_y, 32'h0);
        run_op(2'b10, 0, 2'b00, g);
        chk("t5_y1", last_y, 32'h0);

        // Logic-op flags
        set_req(0, SEL_XOR, 32'h1234_5678, 32'h1234_5678, 1'b0);
        run_op(2'b01, 0, 2'b00, g);
        chk("t6_xor", {last_y, last_f}, {32'h0, 4'b0010});
        set_req(1, SEL_NOT, 32'h0, $urandom(), 1'b0);
        run_op(2'b10, 0, 2'b00, g);
        chk("t6_not", {last_y, last_f}, {32'hFFFF_FFFF, 4'b0100});

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            rand_req(0); rand_req(1);
            run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 2'b00, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
